// File: rtl/conv_fft_pkg.sv
// Shared types and the padded 2x2 -> 4x4 2-D DFT used by every tile lane.
package conv_fft_pkg;

    localparam int FFT_N      = 4;
    localparam int FFT_DATA_W = 32;
    localparam int SPEC_W     = FFT_N * FFT_N * 2 * FFT_DATA_W;

    typedef struct packed {
        logic signed [FFT_DATA_W-1:0] r;
        logic signed [FFT_DATA_W-1:0] i;
    } complex_t;

    typedef complex_t [FFT_N*FFT_N-1:0] spectrum4x4_t;

    typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_e;

    // Accumulate v * W^p with W = -j, so each twiddle is a sign/swap only.
    function automatic complex_t twiddle_acc(input complex_t acc,
                                             input logic signed [FFT_DATA_W-1:0] v,
                                             input logic [1:0] p);
        complex_t res;
        res = acc;
        case (p)
            2'd0:    res.r = acc.r + v;
            2'd1:    res.i = acc.i - v;
            2'd2:    res.r = acc.r - v;
            default: res.i = acc.i + v;
        endcase
        return res;
    endfunction

    // Only in[0][0], in[0][1], in[1][0], in[1][1] are non-zero, so each bin is four terms.
    function automatic spectrum4x4_t fft4_pad(input logic [FFT_N*FFT_DATA_W-1:0] e);
        spectrum4x4_t s;
        complex_t     acc;
        s = '0;
        for (int k = 0; k < FFT_N; k++) begin
            for (int l = 0; l < FFT_N; l++) begin
                acc = '0;
                acc = twiddle_acc(acc, e[0*FFT_DATA_W +: FFT_DATA_W], 2'd0);
                acc = twiddle_acc(acc, e[1*FFT_DATA_W +: FFT_DATA_W], 2'(l));
                acc = twiddle_acc(acc, e[2*FFT_DATA_W +: FFT_DATA_W], 2'(k));
                acc = twiddle_acc(acc, e[3*FFT_DATA_W +: FFT_DATA_W], 2'(k + l));
                s[FFT_N*k + l] = acc;
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/conv_fft_tile_lane.sv
// One tile lane: padded 2-D FFT stage, write staging register and spectrum image memory.
// next_out follows next by one cycle; the memory read has one cycle of latency.
module conv_fft_tile_lane
    import conv_fft_pkg::*;
#(
    parameter int ADDR_W = 13
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      next,
    input  logic [FFT_N*FFT_DATA_W-1:0] tile,
    output logic                      next_out,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic                      rd_en,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic [SPEC_W-1:0]         rd_data
);

    spectrum4x4_t fft_q;
    spectrum4x4_t wr_q;
    spectrum4x4_t rd_q;
    spectrum4x4_t mem [2**ADDR_W];

    // wr_q holds the spectrum for the write one cycle later, freeing fft_q for back-to-back lines.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fft_q    <= '0;
            wr_q     <= '0;
            next_out <= 1'b0;
        end else begin
            next_out <= next;
            if (next)     fft_q <= fft4_pad(tile);
            if (next_out) wr_q  <= fft_q;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_q;
        if (rd_en) rd_q <= mem[rd_addr];
    end

    assign rd_data = rd_q;

endmodule

// File: rtl/conv_fft_tile_buffer.sv
// Frame buffer: FFTs a burst of tiled cachelines into per-tile memory, then drains one tile/part.
// Output register lands 2 cycles after each read issue; reads stall while output_fifo_full is high.
module conv_fft_tile_buffer
    import conv_fft_pkg::*;
#(
    parameter int  NUM_TILES = 4,
    parameter int  DATA_W    = FFT_DATA_W,
    parameter int  ADDR_W    = 13,
    localparam int CL_IN_W   = NUM_TILES * 4 * DATA_W,
    localparam int CL_OUT_W  = 16 * DATA_W,
    localparam int SEL_W     = $clog2(NUM_TILES) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   ctx_length,
    input  logic [SEL_W-1:0]    out_sel,
    input  logic                input_valid,
    input  logic [CL_IN_W-1:0]  cacheline_in,
    input  logic                output_fifo_full,
    output logic                output_valid,
    output logic [CL_OUT_W-1:0] cacheline_out,
    output logic                busy,
    output logic                done,
    output logic                overflow
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   len_q;
    logic [SEL_W-1:0]    sel_q;
    logic [ADDR_W-1:0]   in_cnt;
    logic [ADDR_W-1:0]   wr_addr;
    logic [ADDR_W-1:0]   rd_addr;
    logic                wr_en_q;
    logic                rd_pend;
    logic                accept;
    logic                stray;
    logic                launch;
    logic                rd_en;
    logic [SEL_W-1:0]    tile_idx;
    logic [NUM_TILES-1:0] lane_next_out;
    logic [SPEC_W-1:0]   lane_rd [NUM_TILES];
    spectrum4x4_t        sel_spec;
    logic [CL_OUT_W-1:0] out_d;

    assign launch   = start && (state_q == IDLE || state_q == DONE);
    assign accept   = (state_q == FILL) && input_valid && (in_cnt != len_q);
    assign stray    = input_valid && !accept;
    assign rd_en    = (state_q == DRAIN) && !output_fifo_full && (rd_addr != len_q);
    assign tile_idx = sel_q & SEL_W'(NUM_TILES - 1);

    for (genvar t = 0; t < NUM_TILES; t++) begin : g_lane
        conv_fft_tile_lane #(.ADDR_W(ADDR_W)) u_lane (
            .clk      (clk),
            .reset    (reset),
            .next     (accept),
            .tile     (cacheline_in[t*4*DATA_W +: 4*DATA_W]),
            .next_out (lane_next_out[t]),
            .wr_en    (wr_en_q),
            .wr_addr  (wr_addr),
            .rd_en    (rd_en),
            .rd_addr  (rd_addr),
            .rd_data  (lane_rd[t])
        );
    end

    always_comb begin
        sel_spec = '0;
        for (int t = 0; t < NUM_TILES; t++) begin
            if (tile_idx == SEL_W'(t)) sel_spec = lane_rd[t];
        end
        out_d = '0;
        for (int k = 0; k < FFT_N*FFT_N; k++) begin
            out_d[k*DATA_W +: DATA_W] = sel_q[SEL_W-1] ? sel_spec[k].i : sel_spec[k].r;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = (ctx_length == '0) ? DONE : FILL;
            end
            FILL: begin
                busy = 1'b1;
                if (wr_addr == len_q) state_d = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                // rd_pend low means the last read has reached the output register.
                if (rd_addr == len_q && !rd_pend) state_d = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_d = (ctx_length == '0) ? DONE : FILL;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            len_q         <= '0;
            sel_q         <= '0;
            in_cnt        <= '0;
            wr_addr       <= '0;
            rd_addr       <= '0;
            wr_en_q       <= 1'b0;
            rd_pend       <= 1'b0;
            output_valid  <= 1'b0;
            cacheline_out <= '0;
            overflow      <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_en_q      <= &lane_next_out;
            rd_pend      <= rd_en;
            output_valid <= rd_pend;
            if (rd_pend) cacheline_out <= out_d;
            if (wr_en_q) wr_addr <= wr_addr + ADDR_W'(1);
            if (rd_en)   rd_addr <= rd_addr + ADDR_W'(1);
            if (accept)  in_cnt  <= in_cnt + ADDR_W'(1);
            if (launch) begin
                len_q    <= ctx_length;
                sel_q    <= out_sel;
                in_cnt   <= '0;
                wr_addr  <= '0;
                rd_addr  <= '0;
                overflow <= stray;
            end else if (stray) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_conv_fft_tile_buffer.sv
// Randomized frame bench for conv_fft_tile_buffer against a direct 4x4 DFT reference model.
module tb_conv_fft_tile_buffer;

    localparam int NT  = 4;
    localparam int DW  = 32;
    localparam int AW  = 13;
    localparam int SW  = 3;
    localparam int CLI = NT * 4 * DW;
    localparam int CLO = 16 * DW;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [AW-1:0]  ctx_length;
    logic [SW-1:0]  out_sel;
    logic           input_valid;
    logic [CLI-1:0] cacheline_in;
    logic           output_fifo_full;
    logic           output_valid;
    logic [CLO-1:0] cacheline_out;
    logic           busy;
    logic           done;
    logic           overflow;

    conv_fft_tile_buffer #(.NUM_TILES(NT), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .ctx_length       (ctx_length),
        .out_sel          (out_sel),
        .input_valid      (input_valid),
        .cacheline_in     (cacheline_in),
        .output_fifo_full (output_fifo_full),
        .output_valid     (output_valid),
        .cacheline_out    (cacheline_out),
        .busy             (busy),
        .done             (done),
        .overflow         (overflow)
    );

    always #5 clk = ~clk;

    int             n_chk = 0;
    int             n_pass = 0;
    int             out_cnt = 0;
    int             full_mode = 0;
    logic [CLO-1:0] exp_q [$];
    logic [CLO-1:0] last_out = '0;
    logic [SW-1:0]  cur_sel = '0;
    logic           full_h1 = 1'b0;
    logic           full_h2 = 1'b0;

    task automatic chk(input string tag, input logic [CLO-1:0] got, input logic [CLO-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // X[k][l] = sum over the zero-padded 4x4 input of x[m][n] * exp(-j*2*pi*(mk+nl)/4).
    function automatic logic [CLO-1:0] model_line(input logic [CLI-1:0] line, input logic [SW-1:0] sel);
        int cs[4];
        int sn[4];
        int x[4][4];
        int re, im, tile, p;
        logic [CLO-1:0] res;
        cs = '{1, 0, -1, 0};
        sn = '{0, 1, 0, -1};
        tile = int'(sel[SW-2:0]);
        for (int m = 0; m < 4; m++)
            for (int n = 0; n < 4; n++) x[m][n] = 0;
        x[0][0] = line[tile*128 +  0 +: 32];
        x[0][1] = line[tile*128 + 32 +: 32];
        x[1][0] = line[tile*128 + 64 +: 32];
        x[1][1] = line[tile*128 + 96 +: 32];
        res = '0;
        for (int k = 0; k < 4; k++) begin
            for (int l = 0; l < 4; l++) begin
                re = 0;
                im = 0;
                for (int m = 0; m < 4; m++) begin
                    for (int n = 0; n < 4; n++) begin
                        p  = (m*k + n*l) % 4;
                        re = re + x[m][n] * cs[p];
                        im = im - x[m][n] * sn[p];
                    end
                end
                res[(4*k + l)*32 +: 32] = sel[SW-1] ? im : re;
            end
        end
        return res;
    endfunction

    function automatic logic [CLI-1:0] rand_line();
        logic [CLI-1:0] r;
        for (int i = 0; i < CLI/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int len, input logic [SW-1:0] sel);
        ctx_length = AW'(len);
        out_sel    = sel;
        cur_sel    = sel;
        out_cnt    = 0;
        start      = 1'b1;
        cyc();
        start      = 1'b0;
    endtask

    task automatic send_line(input logic [CLI-1:0] line, input bit expect_it);
        repeat ($urandom_range(0, 2)) cyc();
        input_valid  = 1'b1;
        cacheline_in = line;
        if (expect_it) exp_q.push_back(model_line(line, cur_sel));
        cyc();
        input_valid  = 1'b0;
    endtask

    task automatic wait_done(input int n, input string tag);
        int budget;
        budget = 2000;
        while (!done && budget > 0) begin
            cyc();
            budget--;
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_count"}, out_cnt, n);
        chk({tag, "_pending"}, exp_q.size(), 0);
    endtask

    function automatic logic [SW-1:0] rand_sel();
        return {1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
    endfunction

    // Output monitor: a line visible now was read on the full value seen two samples ago.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && output_valid) begin
                out_cnt++;
                last_out = cacheline_out;
                chk("read_while_full", full_h2, 0);
                if (exp_q.size() == 0) chk("unexpected_output", output_valid, 0);
                else chk("line", cacheline_out, exp_q.pop_front());
            end
            full_h2 = full_h1;
            full_h1 = output_fifo_full;
        end
    end

    initial begin
        int ph;
        ph = 0;
        output_fifo_full = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (full_mode)
                0: output_fifo_full = 1'b0;
                1: begin
                    output_fifo_full = (ph == 0);
                    ph = (ph + 1) % 3;
                end
                default: output_fifo_full = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [CLI-1:0] line;
        int budget;
        reset = 1'b1; start = 1'b0; input_valid = 1'b0;
        ctx_length = '0; out_sel = '0; cacheline_in = '0;
        repeat (3) cyc();
        chk("rst_valid", output_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_out", cacheline_out, 0);
        reset = 1'b0;
        cyc();

        // Single line, real part of tile 0, elements {1,2,3,4}.
        start_frame(1, 3'b000);
        line = rand_line();
        line[127:0] = {32'd4, 32'd3, 32'd2, 32'd1};
        send_line(line, 1);
        wait_done(1, "single");
        chk("single_e0", last_out[31:0], 32'd10);
        chk("single_e1", last_out[63:32], 32'd4);
        chk("single_e2", last_out[95:64], 32'hFFFF_FFFE);
        chk("single_e3", last_out[127:96], 32'd4);
        chk("single_overflow", overflow, 0);

        full_mode = 1;
        start_frame(8, rand_sel());
        repeat (8) send_line(rand_line(), 1);
        wait_done(8, "burst8");

        full_mode = 2;
        start_frame(4, 3'b111);
        repeat (4) send_line(rand_line(), 1);
        wait_done(4, "imag_t3");
        start_frame(4, 3'b111);
        repeat (4) send_line('0, 1);
        wait_done(4, "zero");
        chk("zero_out", last_out, 0);

        full_mode = 0;
        start_frame(0, 3'b000);
        chk("len0_done", done, 1);
        chk("len0_overflow", overflow, 0);
        repeat (3) cyc();
        chk("len0_count", out_cnt, 0);
        input_valid = 1'b1;
        cyc();
        input_valid = 1'b0;
        chk("len0_stray_overflow", overflow, 1);

        start_frame(8, rand_sel());
        repeat (8) send_line(rand_line(), 1);
        budget = 2000;
        while (out_cnt < 3 && budget > 0) begin
            cyc();
            budget--;
        end
        chk("pre_reset_count", out_cnt, 3);
        reset = 1'b1;
        #1;
        chk("midrst_valid", output_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        exp_q.delete();
        repeat (2) cyc();
        reset = 1'b0;
        cyc();
        start_frame(3, rand_sel());
        repeat (3) send_line(rand_line(), 1);
        wait_done(3, "post_reset");

        // Back-to-back frames; the first one also receives one line too many.
        start_frame(2, rand_sel());
        repeat (2) send_line(rand_line(), 1);
        send_line(rand_line(), 0);
        wait_done(2, "b2b_first");
        chk("extra_line_overflow", overflow, 1);
        start_frame(3, rand_sel());
        chk("restart_overflow_clear", overflow, 0);
        chk("restart_busy", busy, 1);
        repeat (3) send_line(rand_line(), 1);
        wait_done(3, "b2b_second");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
